id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage core; sits directly downstream of the stall control mux and upstream of EX (ALU control, forwarding unit, ALU).
- Captures the already-muxed control bundle plus ID-stage operands every enabled cycle.
- Supports hold (memory stall / not started), flush (branch taken), and bubble accounting.
- Also produces the load-use hazard flag consumed by the hazard detection unit, which drives the stall mux.

---
 rtl/id_ex_pipe_reg_pkg.sv | 32 +++
 rtl/id_ex_pipe_reg_if.sv | 74 +++++++
 rtl/id_ex_pipe_reg_ctrl_bundle.sv | 30 +++
 rtl/id_ex_pipe_reg.sv | 94 +++++++++
 tb/tb_id_ex_pipe_reg.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared pipeline definitions: ALU op encodings and the 7-bit
// control bundle carried by ID/EX, EX/MEM and MEM/WB.
package id_ex_pipe_reg_pkg;

  localparam logic [1:0] ALU_OP_R  = 2'b10;
  localparam logic [1:0] ALU_OP_I  = 2'b00;
  localparam logic [1:0] ALU_OP_BR = 2'b01;

  localparam int ALU_OP_W = 2;
  localparam int CTRL_W   = 7;
  localparam int FUNCT_W  = 10;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_write;
  } ctrl_t;

  // ALU_OP_I doubles as the bubble encoding
  localparam ctrl_t CTRL_NOP = '{
    alu_op:     ALU_OP_I,
    alu_src:    1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0
  };

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register.
// master drives the ID side; slave is the register itself.
interface id_ex_pipe_reg_if
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);

  logic               start_i;
  logic               stall_i;
  logic               flush_i;
  logic               bubble_i;
  logic [1:0]         aluOp_i;
  logic               aluSrc_i;
  logic               memRead_i;
  logic               memWrite_i;
  logic               memToReg_i;
  logic               regWrite_i;
  logic [DATA_W-1:0]  pc_i;
  logic [DATA_W-1:0]  rs1Data_i;
  logic [DATA_W-1:0]  rs2Data_i;
  logic [DATA_W-1:0]  imm_i;
  logic [FUNCT_W-1:0] funct_i;
  logic [REG_W-1:0]   rs1Addr_i;
  logic [REG_W-1:0]   rs2Addr_i;
  logic [REG_W-1:0]   rdAddr_i;

  logic [1:0]         aluOp_o;
  logic               aluSrc_o;
  logic               memRead_o;
  logic               memWrite_o;
  logic               memToReg_o;
  logic               regWrite_o;
  logic [DATA_W-1:0]  pc_o;
  logic [DATA_W-1:0]  rs1Data_o;
  logic [DATA_W-1:0]  rs2Data_o;
  logic [DATA_W-1:0]  imm_o;
  logic [FUNCT_W-1:0] funct_o;
  logic [REG_W-1:0]   rs1Addr_o;
  logic [REG_W-1:0]   rs2Addr_o;
  logic [REG_W-1:0]   rdAddr_o;
  logic               valid_o;
  logic               loadUse_o;
  logic [CNT_W-1:0]   bubbleCnt_o;

  modport master (
    output start_i, stall_i, flush_i, bubble_i,
    output aluOp_i, aluSrc_i, memRead_i, memWrite_i,
    output memToReg_i, regWrite_i,
    output pc_i, rs1Data_i, rs2Data_i, imm_i, funct_i,
    output rs1Addr_i, rs2Addr_i, rdAddr_i,
    input  aluOp_o, aluSrc_o, memRead_o, memWrite_o,
    input  memToReg_o, regWrite_o,
    input  pc_o, rs1Data_o, rs2Data_o, imm_o, funct_o,
    input  rs1Addr_o, rs2Addr_o, rdAddr_o,
    input  valid_o, loadUse_o, bubbleCnt_o
  );

  modport slave (
    input  start_i, stall_i, flush_i, bubble_i,
    input  aluOp_i, aluSrc_i, memRead_i, memWrite_i,
    input  memToReg_i, regWrite_i,
    input  pc_i, rs1Data_i, rs2Data_i, imm_i, funct_i,
    input  rs1Addr_i, rs2Addr_i, rdAddr_i,
    output aluOp_o, aluSrc_o, memRead_o, memWrite_o,
    output memToReg_o, regWrite_o,
    output pc_o, rs1Data_o, rs2Data_o, imm_o, funct_o,
    output rs1Addr_o, rs2Addr_o, rdAddr_o,
    output valid_o, loadUse_o, bubbleCnt_o
  );

endinterface

// File: rtl/id_ex_pipe_reg_ctrl_bundle.sv
// Control bundle + valid flop with hold and bubble insertion.
// Shared by every inter-stage register of the core.
module pipe_ctrl_bundle_reg
  import id_ex_pipe_reg_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  bubble,
  input  ctrl_t d,
  output ctrl_t q,
  output logic  valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= CTRL_NOP;
      valid <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        q     <= CTRL_NOP;
        valid <= 1'b0;
      end else begin
        q     <= d;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: control bundle, operands, bubble
// counter and the load-use hazard flag for the stall mux.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  id_ex_pipe_reg_if.slave bus
);

  logic              hold;
  logic              kill;
  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  logic              valid;
  logic [REG_W-1:0]  rd_q;
  logic [CNT_W-1:0]  cnt;
  logic              hit;

  assign hold = !bus.start_i || bus.stall_i;
  // flush and bubble collapse into one bubble
  assign kill = bus.flush_i || bus.bubble_i;

  assign ctrl_d = '{
    alu_op:     bus.aluOp_i,
    alu_src:    bus.aluSrc_i,
    mem_read:   bus.memRead_i,
    mem_write:  bus.memWrite_i,
    mem_to_reg: bus.memToReg_i,
    reg_write:  bus.regWrite_i
  };

  pipe_ctrl_bundle_reg u_ctrl (
    .clk    (clk_i),
    .rst    (rst_i),
    .hold   (hold),
    .bubble (kill),
    .d      (ctrl_d),
    .q      (ctrl_q),
    .valid  (valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.pc_o      <= '0;
      bus.rs1Data_o <= '0;
      bus.rs2Data_o <= '0;
      bus.imm_o     <= '0;
      bus.funct_o   <= '0;
      bus.rs1Addr_o <= '0;
      bus.rs2Addr_o <= '0;
      rd_q          <= '0;
    end else if (!hold) begin
      bus.pc_o      <= bus.pc_i;
      bus.rs1Data_o <= bus.rs1Data_i;
      bus.rs2Data_o <= bus.rs2Data_i;
      bus.imm_o     <= bus.imm_i;
      bus.funct_o   <= bus.funct_i;
      bus.rs1Addr_o <= bus.rs1Addr_i;
      bus.rs2Addr_o <= bus.rs2Addr_i;
      rd_q          <= kill ? '0 : bus.rdAddr_i;
    end
  end

  // saturating: stays at all-ones once reached
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= '0;
    else if (!hold && kill && !(&cnt))
      cnt <= cnt + CNT_W'(1);
  end

  assign hit = (rd_q == bus.rs1Addr_i) ||
               (rd_q == bus.rs2Addr_i);

  assign bus.loadUse_o = !bus.stall_i && valid &&
                         ctrl_q.mem_read &&
                         (rd_q != '0) && hit;

  assign bus.aluOp_o     = ctrl_q.alu_op;
  assign bus.aluSrc_o    = ctrl_q.alu_src;
  assign bus.memRead_o   = ctrl_q.mem_read;
  assign bus.memWrite_o  = ctrl_q.mem_write;
  assign bus.memToReg_o  = ctrl_q.mem_to_reg;
  assign bus.regWrite_o  = ctrl_q.reg_write;
  assign bus.rdAddr_o    = rd_q;
  assign bus.valid_o     = valid;
  assign bus.bubbleCnt_o = cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg, plus a
// 4-bit-counter instance for the saturation case.
module tb_id_ex_pipe_reg;
  import id_ex_pipe_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(32), .REG_W(5), .CNT_W(32)) bus ();
  id_ex_pipe_reg_if #(.DATA_W(32), .REG_W(5), .CNT_W(4))  bus4 ();

  id_ex_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  id_ex_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.start_i    = 1'b1;
    bus.stall_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.bubble_i   = 1'b0;
    bus.aluOp_i    = 2'b00;
    bus.aluSrc_i   = 1'b0;
    bus.memRead_i  = 1'b0;
    bus.memWrite_i = 1'b0;
    bus.memToReg_i = 1'b0;
    bus.regWrite_i = 1'b0;
    bus.pc_i       = '0;
    bus.rs1Data_i  = '0;
    bus.rs2Data_i  = '0;
    bus.imm_i      = '0;
    bus.funct_i    = '0;
    bus.rs1Addr_i  = '0;
    bus.rs2Addr_i  = '0;
    bus.rdAddr_i   = '0;
  endtask

  task automatic idle4();
    bus4.start_i    = 1'b0;
    bus4.stall_i    = 1'b0;
    bus4.flush_i    = 1'b0;
    bus4.bubble_i   = 1'b0;
    bus4.aluOp_i    = 2'b00;
    bus4.aluSrc_i   = 1'b0;
    bus4.memRead_i  = 1'b0;
    bus4.memWrite_i = 1'b0;
    bus4.memToReg_i = 1'b0;
    bus4.regWrite_i = 1'b0;
    bus4.pc_i       = '0;
    bus4.rs1Data_i  = '0;
    bus4.rs2Data_i  = '0;
    bus4.imm_i      = '0;
    bus4.funct_i    = '0;
    bus4.rs1Addr_i  = '0;
    bus4.rs2Addr_i  = '0;
    bus4.rdAddr_i   = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.aluOp_i    = ALU_OP_R;
    bus.aluSrc_i   = 1'b1;
    bus.memRead_i  = 1'b1;
    bus.memWrite_i = 1'b1;
    bus.memToReg_i = 1'b1;
    bus.regWrite_i = 1'b1;
    bus.pc_i       = 32'h0000_0100;
    bus.rs1Data_i  = 32'hAAAA_5555;
    bus.rs2Data_i  = 32'h5555_AAAA;
    bus.imm_i      = 32'hFFFF_FFF0;
    bus.funct_i    = 10'h3FF;
    bus.rs1Addr_i  = 5'd3;
    bus.rs2Addr_i  = 5'd4;
    bus.rdAddr_i   = 5'd3;
    bus.bubble_i   = 1'b1;
    step();
    bus.bubble_i   = 1'b0;
    step();
    // hazard is live: rd=3 matches rs1=3 with memRead set
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got %0h want 0", bus.valid_o);
    end
    n_cmp++;
    if ({bus.aluOp_o, bus.aluSrc_o, bus.memRead_o, bus.memWrite_o,
         bus.memToReg_o, bus.regWrite_o} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl got %0h want 0", {bus.aluOp_o,
               bus.aluSrc_o, bus.memRead_o, bus.memWrite_o,
               bus.memToReg_o, bus.regWrite_o});
    end
    n_cmp++;
    if ({bus.pc_o, bus.rs1Data_o, bus.rs2Data_o, bus.imm_o} !== 128'd0)
    begin
      n_bad++;
      $display("FAIL reset_data got %0h want 0",
               {bus.pc_o, bus.rs1Data_o, bus.rs2Data_o, bus.imm_o});
    end
    n_cmp++;
    if ({bus.funct_o, bus.rs1Addr_o, bus.rs2Addr_o, bus.rdAddr_o}
        !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_addr got %0h want 0",
               {bus.funct_o, bus.rs1Addr_o, bus.rs2Addr_o, bus.rdAddr_o});
    end
    n_cmp++;
    if (bus.bubbleCnt_o !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got %0h want 0", bus.bubbleCnt_o);
    end
    n_cmp++;
    if (bus.loadUse_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_loaduse got %0h want 0", bus.loadUse_o);
    end
    #2;
    rst = 1'b0;
    idle();
    @(negedge clk);
  endtask

  task automatic test_load();
    idle();
    bus.regWrite_i = 1'b1;
    bus.aluOp_i    = ALU_OP_R;
    bus.rs1Data_i  = 32'h1234_5678;
    bus.rs2Data_i  = 32'h0BAD_F00D;
    bus.funct_i    = 10'h205;
    bus.pc_i       = 32'h0000_0040;
    bus.rdAddr_i   = 5'd5;
    step();
    n_cmp++;
    if (bus.regWrite_o !== 1'b1) begin
      n_bad++;
      $display("FAIL load_regwrite got %0h want 1", bus.regWrite_o);
    end
    n_cmp++;
    if (bus.aluOp_o !== 2'b10) begin
      n_bad++;
      $display("FAIL load_aluop got %0h want 2", bus.aluOp_o);
    end
    n_cmp++;
    if (bus.rs1Data_o !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL load_rs1data got %0h want 12345678", bus.rs1Data_o);
    end
    n_cmp++;
    if ({bus.rs2Data_o, bus.funct_o, bus.pc_o}
        !== {32'h0BAD_F00D, 10'h205, 32'h0000_0040}) begin
      n_bad++;
      $display("FAIL load_data got %0h/%0h/%0h want bad f00d/205/40",
               bus.rs2Data_o, bus.funct_o, bus.pc_o);
    end
    n_cmp++;
    if (bus.rdAddr_o !== 5'd5) begin
      n_bad++;
      $display("FAIL load_rd got %0d want 5", bus.rdAddr_o);
    end
    n_cmp++;
    if (bus.valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL load_valid got %0h want 1", bus.valid_o);
    end
    // start low must freeze everything
    bus.start_i   = 1'b0;
    bus.rs1Data_i = 32'hDEAD_BEEF;
    bus.rdAddr_i  = 5'd9;
    bus.bubble_i  = 1'b1;
    step();
    n_cmp++;
    if ({bus.rs1Data_o, bus.rdAddr_o, bus.valid_o, bus.bubbleCnt_o}
        !== {32'h1234_5678, 5'd5, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL nostart_hold got %0h/%0d/%0h/%0d want 12345678/5/1/0",
               bus.rs1Data_o, bus.rdAddr_o, bus.valid_o, bus.bubbleCnt_o);
    end
  endtask

  task automatic test_load_use();
    idle();
    bus.memRead_i  = 1'b1;
    bus.memToReg_i = 1'b1;
    bus.regWrite_i = 1'b1;
    bus.rdAddr_i   = 5'd7;
    step();
    bus.memRead_i  = 1'b0;
    bus.rs1Addr_i  = 5'd3;
    bus.rs2Addr_i  = 5'd7;
    #1;
    n_cmp++;
    if (bus.loadUse_o !== 1'b1) begin
      n_bad++;
      $display("FAIL loaduse_rs2 got %0h want 1", bus.loadUse_o);
    end
    bus.rs1Addr_i = 5'd7;
    bus.rs2Addr_i = 5'd2;
    #1;
    n_cmp++;
    if (bus.loadUse_o !== 1'b1) begin
      n_bad++;
      $display("FAIL loaduse_rs1 got %0h want 1", bus.loadUse_o);
    end
    bus.rs1Addr_i = 5'd6;
    bus.rs2Addr_i = 5'd8;
    #1;
    n_cmp++;
    if (bus.loadUse_o !== 1'b0) begin
      n_bad++;
      $display("FAIL loaduse_nomatch got %0h want 0", bus.loadUse_o);
    end
    bus.rs1Addr_i = 5'd7;
    bus.stall_i   = 1'b1;
    #1;
    n_cmp++;
    if (bus.loadUse_o !== 1'b0) begin
      n_bad++;
      $display("FAIL loaduse_stall got %0h want 0", bus.loadUse_o);
    end
    bus.stall_i   = 1'b0;
    bus.memRead_i = 1'b1;
    bus.rdAddr_i  = 5'd0;
    bus.rs1Addr_i = 5'd0;
    bus.rs2Addr_i = 5'd0;
    step();
    n_cmp++;
    if (bus.loadUse_o !== 1'b0) begin
      n_bad++;
      $display("FAIL loaduse_x0 got %0h want 0", bus.loadUse_o);
    end
    // a non-load writing rd must not flag a hazard
    bus.memRead_i = 1'b0;
    bus.rdAddr_i  = 5'd7;
    bus.rs1Addr_i = 5'd7;
    step();
    n_cmp++;
    if (bus.loadUse_o !== 1'b0) begin
      n_bad++;
      $display("FAIL loaduse_noload got %0h want 0", bus.loadUse_o);
    end
  endtask

  task automatic test_bubble_flush();
    idle();
    bus.regWrite_i = 1'b1;
    bus.memWrite_i = 1'b1;
    bus.aluOp_i    = ALU_OP_BR;
    bus.aluSrc_i   = 1'b1;
    bus.rdAddr_i   = 5'd12;
    bus.pc_i       = 32'h0000_0200;
    bus.bubble_i   = 1'b1;
    step();
    n_cmp++;
    if ({bus.aluOp_o, bus.aluSrc_o, bus.memWrite_o, bus.regWrite_o,
         bus.rdAddr_o, bus.valid_o} !== 10'd0) begin
      n_bad++;
      $display("FAIL bubble_ctrl got %0h want 0", {bus.aluOp_o,
               bus.aluSrc_o, bus.memWrite_o, bus.regWrite_o,
               bus.rdAddr_o, bus.valid_o});
    end
    n_cmp++;
    if (bus.pc_o !== 32'h0000_0200) begin
      n_bad++;
      $display("FAIL bubble_pc got %0h want 200", bus.pc_o);
    end
    n_cmp++;
    if (bus.bubbleCnt_o !== 32'd1) begin
      n_bad++;
      $display("FAIL bubble_cnt1 got %0d want 1", bus.bubbleCnt_o);
    end
    bus.flush_i = 1'b1;
    bus.pc_i    = 32'h0000_0204;
    step();
    n_cmp++;
    if ({bus.aluOp_o, bus.regWrite_o, bus.rdAddr_o, bus.valid_o}
        !== 9'd0) begin
      n_bad++;
      $display("FAIL flush_ctrl got %0h want 0",
               {bus.aluOp_o, bus.regWrite_o, bus.rdAddr_o, bus.valid_o});
    end
    n_cmp++;
    if (bus.bubbleCnt_o !== 32'd2) begin
      n_bad++;
      $display("FAIL flush_cnt2 got %0d want 2", bus.bubbleCnt_o);
    end
  endtask

  task automatic test_stall_priority();
    idle();
    bus.memRead_i  = 1'b1;
    bus.regWrite_i = 1'b1;
    bus.rdAddr_i   = 5'd9;
    bus.pc_i       = 32'h0000_0300;
    bus.imm_i      = 32'h0000_0010;
    step();
    bus.stall_i   = 1'b1;
    bus.flush_i   = 1'b1;
    bus.memRead_i = 1'b0;
    bus.rdAddr_i  = 5'd1;
    bus.pc_i      = 32'h0000_0304;
    bus.imm_i     = 32'h0000_0099;
    bus.rs1Addr_i = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.valid_o, bus.memRead_o, bus.rdAddr_o, bus.pc_o,
           bus.imm_o, bus.bubbleCnt_o}
          !== {1'b1, 1'b1, 5'd9, 32'h0000_0300, 32'h0000_0010, 32'd2})
      begin
        n_bad++;
        $display("FAIL stall_hold%0d got %0h/%0h/%0d/%0h/%0h/%0d want 1/1/9/300/10/2",
                 i, bus.valid_o, bus.memRead_o, bus.rdAddr_o,
                 bus.pc_o, bus.imm_o, bus.bubbleCnt_o);
      end
      n_cmp++;
      if (bus.loadUse_o !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_loaduse%0d got %0h want 0", i, bus.loadUse_o);
      end
    end
    bus.stall_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.loadUse_o !== 1'b1) begin
      n_bad++;
      $display("FAIL unstall_loaduse got %0h want 1", bus.loadUse_o);
    end
    step();
    n_cmp++;
    if ({bus.valid_o, bus.rdAddr_o, bus.pc_o, bus.bubbleCnt_o}
        !== {1'b0, 5'd0, 32'h0000_0304, 32'd3}) begin
      n_bad++;
      $display("FAIL late_flush got %0h/%0d/%0h/%0d want 0/0/304/3",
               bus.valid_o, bus.rdAddr_o, bus.pc_o, bus.bubbleCnt_o);
    end
    idle();
  endtask

  task automatic test_saturation();
    idle4();
    bus4.start_i  = 1'b1;
    bus4.bubble_i = 1'b1;
    for (int i = 0; i < 14; i++)
      step();
    n_cmp++;
    if (bus4.bubbleCnt_o !== 4'hE) begin
      n_bad++;
      $display("FAIL sat_preload got %0h want e", bus4.bubbleCnt_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus4.bubbleCnt_o !== 4'hF) begin
        n_bad++;
        $display("FAIL sat_hold%0d got %0h want f", i, bus4.bubbleCnt_o);
      end
    end
    idle4();
  endtask

  initial begin
    idle();
    idle4();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_load();
    test_load_use();
    test_bubble_flush();
    test_stall_priority();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
